// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: 4-digit BCD up/down counter with multiplexed digit scan.
// Define BLANK_LEADING_ZEROS_EN to blank leading-zero digits (b=4'b1111).
module bcd_scan_counter #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] b,
    output logic [3:0] an,
    output logic       ovf
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]   pre, pre_n;
    logic [1:0]      idx, idx_n;
    logic [3:0][3:0] d, d_n;
    logic            c, wrap, last;
    logic [3:0]      b_n;
`ifdef BLANK_LEADING_ZEROS_EN
    logic            lz;
`endif

    // Next count: ripple decimal carry/borrow through the digits; a carry out of d3 is a wrap.
    always_comb begin
        d_n  = d;
        c    = 1'b1;
        wrap = 1'b0;
        if (clr) begin
            d_n = '0;
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (c) begin
                    if (up) begin
                        d_n[k] = (d[k] == 4'd9) ? 4'd0 : d[k] + 4'd1;
                        c      = (d[k] == 4'd9);
                    end else begin
                        d_n[k] = (d[k] == 4'd0) ? 4'd9 : d[k] - 4'd1;
                        c      = (d[k] == 4'd0);
                    end
                end
            end
            wrap = c;
        end
    end

    // Prescaler and scan index advance, free-running regardless of en/clr.
    always_comb begin
        last  = (pre == PW'(SCAN_DIV - 1));
        pre_n = last ? '0 : pre + 1'b1;
        idx_n = last ? idx + 2'd1 : idx;
    end

    // Displayed digit uses next-state values so b tracks the count with no extra lag.
`ifdef BLANK_LEADING_ZEROS_EN
    always_comb begin
        b_n = d_n[idx_n];
        lz  = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            lz = lz & (d_n[k] == 4'd0);
            if (idx_n == 2'(k) && lz) b_n = 4'hf;
        end
    end
`else
    always_comb b_n = d_n[idx_n];
`endif

    // All state and registered outputs; an and b load from the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= 2'd0;
            d   <= '0;
            an  <= 4'b1110;
            b   <= 4'd0;
            ovf <= 1'b0;
        end else begin
            pre <= pre_n;
            idx <= idx_n;
            d   <= d_n;
            an  <= ~(4'b0001 << idx_n);
            b   <= b_n;
            ovf <= wrap;
        end
    end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed stimulus with a decimal-arithmetic reference model.
module tb_bcd_scan_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0;
    logic [3:0] b, an;
    logic       ovf;
    int         total = 0, bad = 0;
    bit         chk = 1'b0;

    int m_cnt = 0, m_tick = 0;
    bit m_ovf = 1'b0;

    bcd_scan_counter #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
        .b(b), .an(an), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain decimal arithmetic on an integer count and a cycle counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_tick = 0; m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (clr) m_cnt = 0;
            else if (en && up) begin m_ovf = (m_cnt == 9999); m_cnt = (m_cnt + 1) % 10000; end
            else if (en) begin m_ovf = (m_cnt == 0); m_cnt = (m_cnt + 9999) % 10000; end
            m_tick++;
        end
    end

    function automatic int exp_b(input int cnt, input int i);
        int p = 1;
        for (int j = 0; j < i; j++) p *= 10;
`ifdef BLANK_LEADING_ZEROS_EN
        if (i >= 1 && cnt < p) return 15;
`endif
        return (cnt / p) % 10;
    endfunction

    // Continuous comparison of all outputs against the model.
    always @(negedge clk) if (chk) begin
        int i;
        i = (m_tick / 4) % 4;
        check("an", an, 4'hf & ~(1 << i));
        check("b", b, exp_b(m_cnt, i));
        check("ovf", ovf, m_ovf);
    end

    task automatic step(input bit e, input bit u, input bit c);
        en = e; up = u; clr = c;
        @(negedge clk);
    endtask

    task automatic load(input int v);
        step(1'b0, 1'b0, 1'b1);
        repeat (v) step(1'b1, 1'b1, 1'b0);
        en = 1'b0;
    endtask

    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef BLANK_LEADING_ZEROS_EN
    int s42 [4] = '{2, 4, 15, 15};
    int s00 [4] = '{0, 15, 15, 15};
`else
    int s42 [4] = '{2, 4, 0, 0};
    int s00 [4] = '{0, 0, 0, 0};
`endif

    task automatic scan_check(input string name, input int exp [4]);
        int got [4];
        for (int i = 0; i < 4; i++) got[i] = -1;
        repeat (16) begin
            for (int k = 0; k < 4; k++) if (an == an_seq[k]) got[k] = b;
            step(1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) check(name, got[k], exp[k]);
    endtask

    initial begin
        int n_ovf, at;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("scan_an", an, an_seq[i / 4]);
            check("scan_b", b, 0);
            step(1'b0, 1'b0, 1'b0);
        end
        n_ovf = 0; at = -1;
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (ovf) begin n_ovf++; at = i; end
        end
        check("up_ovf_count", n_ovf, 1);
        check("up_ovf_at", at, 9999);
        check("up_model_cnt", m_cnt, 0);
        step(1'b1, 1'b0, 1'b0);
        check("down_wrap_ovf", ovf, 1);
        check("down_wrap_cnt", m_cnt, 9999);
        step(1'b1, 1'b0, 1'b0);
        check("down_next_ovf", ovf, 0);
        check("down_next_cnt", m_cnt, 9998);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        check("hold_cnt", m_cnt, 9998);
        load(199);
        step(1'b1, 1'b1, 1'b1);
        check("clr_cnt", m_cnt, 0);
        check("clr_ovf", ovf, 0);
        load(42);
        step(1'b0, 1'b0, 1'b0);
        scan_check("scan42", s42);
        step(1'b0, 1'b0, 1'b1);
        scan_check("scan0", s00);
        load(357);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_an", an, 4'b1110);
        check("arst_b", b, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("rel_an", an, an_seq[i / 4]);
            step(1'b0, 1'b0, 1'b0);
        end
        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each digit stays selected (legal range 2..2^20).
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port en  input  1  count enable, sampled each rising edge; one step per cycle while high.
REQ-005 Port up  input  1  direction, 1 = increment, 0 = decrement; sampled with en.
REQ-006 Port clr  input  1  synchronous clear of the count to 0000.
REQ-007 Port b  output  4  BCD value of the currently selected digit, registered; feeds the 7-segment driver input.
REQ-008 Port an  output  4  digit select, one-hot active-low, registered; bit k low selects digit k (k=0 is least significant).
REQ-009 Port ovf  output  1  one-cycle pulse on count wrap, registered.
REQ-010 One clock (clk); reset asynchronous active-low (rst_n), as decided.

Function
REQ-011 Count shall be four BCD digits d3..d0, each always within 0..9, total range 0000..9999.
REQ-012 clr=1 shall load 0000 on the next edge, overriding en/up, with ovf=0.
REQ-013 en=1, up=1, clr=0: increment with decimal carry (d0 9->0 carries into d1, and so on).
REQ-014 en=1, up=0, clr=0: decrement with decimal borrow (d0 0->9 borrows from d1, and so on).
REQ-015 Wrap 9999->0000 (up) or 0000->9999 (down) shall set ovf=1 for exactly the cycle following that edge; ovf=0 otherwise.
REQ-016 en=0 and clr=0: count shall hold; up is ignored.
REQ-017 Prescaler shall count 0..SCAN_DIV-1 continuously, independent of en/clr; at SCAN_DIV-1 it returns to 0 and the scan index advances 0->1->2->3->0.
REQ-018 an shall equal ~(1<<idx) and b shall equal digit[idx] (subject to REQ-025), both registered from the same edge so they change together; an shall never have more than one bit low.
REQ-019 b shall reflect a count change no later than one clk cycle after the edge that changed the count, including mid-slot changes.
REQ-020 b shall only ever carry 0..9, or 4'b1111 for blank; the downstream driver shows all segments off for 4'b1111.

Reset
REQ-021 rst_n low shall immediately force count 0000, prescaler 0, idx 0, an=4'b1110, b=4'b0000, ovf=0, regardless of clk.
REQ-022 Reset asserted mid-count or mid-slot shall discard all state; no ovf pulse shall be generated by reset or its release.
REQ-023 On the first edge after rst_n rises, the block shall behave as at prescaler 0, idx 0.

Configuration
REQ-024 Macro BLANK_LEADING_ZEROS_EN shall select leading-zero blanking at compile time.
REQ-025 With BLANK_LEADING_ZEROS_EN defined: when idx=k>=1 and dk and all higher digits are 0, b shall be 4'b1111; digit 0 is never blanked (0000 displays "0").
REQ-026 Without BLANK_LEADING_ZEROS_EN: b shall always equal digit[idx]; no blanking logic present.

Verification (bench uses SCAN_DIV=4)
REQ-027 Reset release, en=0 for 16 cycles -> an cycles 1110,1101,1011,0111, 4 cycles each, b=0 throughout (macro off).
REQ-028 Count 0000, en=1 up=1 for 10000 cycles -> count returns to 0000, ovf high exactly once, in the cycle after the 9999->0000 edge.
REQ-029 Count 0000, en=1 up=0 for 1 cycle -> count 9999, ovf pulses once; then 1 more cycle -> 9998, ovf=0.
REQ-030 Count 0199, en=1 and clr=1 simultaneously -> count 0000, ovf=0.
REQ-031 Macro on, count 0042 -> b over one scan: 2, 4, 1111, 1111; count 0000 -> 0, 1111, 1111, 1111.
REQ-032 rst_n pulsed low mid-slot at count 0357 -> outputs reach reset values without a clk edge; subsequent scan restarts at idx 0 with count 0000.
